// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory req/ack on one side,
// decode valid/ready plus next-PC select on the other.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [2:0]  pc_sel;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, inst, inst_pc,
        input  inst_ready, pc_sel,
        input  jump_target, branch_target,
        output fault, fault_pc, fetch_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, inst, inst_pc,
        output inst_ready, pc_sel,
        output jump_target, branch_target,
        input  fault, fault_pc, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack,
// hands instructions to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_REQ,
        S_OUT,
        S_FAULT
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state;
    logic [31:0] pc;
    logic [7:0]  wait_cnt;
    logic [31:0] next_pc;

    // Next-PC select; reserved encodings fall through to pc+4
    always_comb begin
        next_pc = pc + 32'd4;
        case (bus.pc_sel)
            3'd2:    next_pc = bus.jump_target;
            3'd3:    next_pc = bus.branch_target;
            default: next_pc = pc + 32'd4;
        endcase
    end

    // Request is held low while reset is asserted
    assign bus.imem_req  = (state == S_REQ) && !rst;
    assign bus.imem_addr = pc;

    // Fetch FSM with registered decode-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_REQ;
            pc              <= RESET_PC;
            wait_cnt        <= 8'd0;
            bus.inst_valid  <= 1'b0;
            bus.inst        <= NOP;
            bus.inst_pc     <= 32'd0;
            bus.fault       <= 1'b0;
            bus.fault_pc    <= 32'd0;
            bus.fetch_count <= 32'd0;
        end else begin
            case (state)
                S_REQ: begin
                    if (bus.imem_ack) begin
                        bus.inst       <= bus.imem_rdata;
                        bus.inst_pc    <= pc;
                        bus.inst_valid <= 1'b1;
                        wait_cnt       <= 8'd0;
                        state          <= S_OUT;
                    end else if (wait_cnt == TO_LAST) begin
                        bus.fault    <= 1'b1;
                        bus.fault_pc <= pc;
                        state        <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_OUT: begin
                    if (bus.inst_ready) begin
                        bus.fetch_count <= bus.fetch_count + 32'd1;
                        bus.inst_valid  <= 1'b0;
                        if (next_pc[1:0] == 2'b00) begin
                            pc    <= next_pc;
                            state <= S_REQ;
                        end else begin
                            bus.fault    <= 1'b1;
                            bus.fault_pc <= next_pc;
                            state        <= S_FAULT;
                        end
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table of fetches plus
// hand sequences for backpressure, faults, reset and PC wrap.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .TIMEOUT  (16)
    ) dut_wrap (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.master)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          wait_n;
        logic [2:0]  sel;
        logic [31:0] jt;
        logic [31:0] bt;
        logic [31:0] next;
    } vec_t;

    vec_t vecs [8];
    int   total = 0;
    int   passed = 0;
    logic [31:0] exp_count = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One memory transaction plus decode accept, checked end to end
    task automatic do_fetch(input vec_t v);
        chk("req_start", 32'(bus.imem_req), 32'd1);
        chk("addr", bus.imem_addr, v.pc);
        bus.imem_ack = 1'b0;
        for (int w = 0; w < v.wait_n; w++) tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = v.rdata;
        tick();
        bus.imem_ack = 1'b0;
        chk("valid_after_ack", 32'(bus.inst_valid), 32'd1);
        chk("inst", bus.inst, v.rdata);
        chk("inst_pc", bus.inst_pc, v.pc);
        chk("req_in_out", 32'(bus.imem_req), 32'd0);
        chk("no_fault", 32'(bus.fault), 32'd0);
        bus.inst_ready    = 1'b1;
        bus.pc_sel        = v.sel;
        bus.jump_target   = v.jt;
        bus.branch_target = v.bt;
        tick();
        bus.inst_ready = 1'b0;
        exp_count++;
        chk("valid_after_acc", 32'(bus.inst_valid), 32'd0);
        chk("req_next", 32'(bus.imem_req), 32'd1);
        chk("next_addr", bus.imem_addr, v.next);
        chk("fetch_count", bus.fetch_count, exp_count);
    endtask

    initial begin
        vecs[0] = '{32'h000, 32'h00500093, 0, 3'd0, 32'h0, 32'h0, 32'h004};
        vecs[1] = '{32'h004, 32'h00a00113, 0, 3'd0, 32'h0, 32'h0, 32'h008};
        vecs[2] = '{32'h008, 32'h00f00193, 1, 3'd3, 32'h80, 32'h40, 32'h040};
        vecs[3] = '{32'h040, 32'h0000006f, 2, 3'd2, 32'h100, 32'h44, 32'h100};
        vecs[4] = '{32'h100, 32'h00000013, 0, 3'd5, 32'h200, 32'h300, 32'h104};
        vecs[5] = '{32'h104, 32'h12345678, 0, 3'd1, 32'h200, 32'h300, 32'h108};
        vecs[6] = '{32'h108, 32'h89abcdef, 0, 3'd7, 32'h200, 32'h300, 32'h10c};
        vecs[7] = '{32'h110, 32'hcafef00d, 3, 3'd0, 32'h0, 32'h0, 32'h114};

        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = 32'd0;
        bus.inst_ready    = 1'b0;
        bus.pc_sel        = 3'd0;
        bus.jump_target   = 32'd0;
        bus.branch_target = 32'd0;
        bus2.imem_ack      = 1'b0;
        bus2.imem_rdata    = 32'd0;
        bus2.inst_ready    = 1'b0;
        bus2.pc_sel        = 3'd0;
        bus2.jump_target   = 32'd0;
        bus2.branch_target = 32'd0;

        tick();
        tick();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, 32'h0000_0013);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_fault_pc", bus.fault_pc, 32'd0);
        chk("rst_count", bus.fetch_count, 32'd0);
        rst = 1'b0;
        #1;

        for (int i = 0; i < 7; i++) do_fetch(vecs[i]);

        // Backpressure: decode stalls while select inputs churn
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h00c00193;
        tick();
        bus.imem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.pc_sel      = 3'(k + 2);
            bus.jump_target = 32'h0000_0555 + 32'(k);
            tick();
            chk("bp_inst", bus.inst, 32'h00c00193);
            chk("bp_inst_pc", bus.inst_pc, 32'h10c);
            chk("bp_req", 32'(bus.imem_req), 32'd0);
            chk("bp_valid", 32'(bus.inst_valid), 32'd1);
            chk("bp_count", bus.fetch_count, exp_count);
        end
        bus.inst_ready = 1'b1;
        bus.pc_sel     = 3'd0;
        tick();
        bus.inst_ready = 1'b0;
        exp_count++;
        chk("bp_next_addr", bus.imem_addr, 32'h110);
        chk("bp_next_count", bus.fetch_count, exp_count);

        // Ack on the last allowed wait cycle wins over timeout
        do_fetch(vecs[7]);

        // Misaligned jump target faults and sticks
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0020006f;
        tick();
        bus.imem_ack    = 1'b0;
        bus.inst_ready  = 1'b1;
        bus.pc_sel      = 3'd2;
        bus.jump_target = 32'h102;
        tick();
        exp_count++;
        chk("mis_fault", 32'(bus.fault), 32'd1);
        chk("mis_fault_pc", bus.fault_pc, 32'h102);
        chk("mis_req", 32'(bus.imem_req), 32'd0);
        chk("mis_valid", 32'(bus.inst_valid), 32'd0);
        chk("mis_count", bus.fetch_count, exp_count);
        bus.imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        bus.imem_ack   = 1'b0;
        bus.inst_ready = 1'b0;
        chk("mis_hold_req", 32'(bus.imem_req), 32'd0);
        chk("mis_hold_valid", 32'(bus.inst_valid), 32'd0);
        chk("mis_hold_pc", bus.imem_addr, 32'h114);
        chk("mis_hold_count", bus.fetch_count, exp_count);
        chk("mis_hold_fault", 32'(bus.fault), 32'd1);

        // Async reset clears the fault without a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("arst_fault", 32'(bus.fault), 32'd0);
        chk("arst_fault_pc", bus.fault_pc, 32'd0);
        chk("arst_count", bus.fetch_count, 32'd0);
        tick();
        rst = 1'b0;
        exp_count = 0;
        #1;
        chk("to_req0", 32'(bus.imem_req), 32'd1);
        chk("to_addr0", bus.imem_addr, 32'd0);

        // Timeout with ack held low for four request cycles
        for (int k = 0; k < 3; k++) tick();
        chk("to_nofault3", 32'(bus.fault), 32'd0);
        chk("to_req3", 32'(bus.imem_req), 32'd1);
        tick();
        chk("to_fault", 32'(bus.fault), 32'd1);
        chk("to_fault_pc", bus.fault_pc, 32'd0);
        chk("to_req_off", 32'(bus.imem_req), 32'd0);

        // Reset while a request is outstanding
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        do_fetch(vecs[0]);
        tick();
        chk("mw_req", 32'(bus.imem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mw_req", 32'(bus.imem_req), 32'd0);
        chk("mw_addr", bus.imem_addr, 32'd0);
        chk("mw_count", bus.fetch_count, 32'd0);
        chk("mw_inst", bus.inst, 32'h0000_0013);
        chk("mw_inst_pc", bus.inst_pc, 32'd0);
        chk("mw_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mw_rel_req", 32'(bus.imem_req), 32'd1);
        chk("mw_rel_addr", bus.imem_addr, 32'd0);

        // PC wrap from the top of the address space
        rst2 = 1'b0;
        #1;
        chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        bus2.imem_ack   = 1'b1;
        bus2.imem_rdata = 32'h00100093;
        tick();
        bus2.imem_ack = 1'b0;
        chk("wrap_inst_pc", bus2.inst_pc, 32'hFFFF_FFFC);
        bus2.inst_ready = 1'b1;
        tick();
        bus2.inst_ready = 1'b0;
        chk("wrap_next", bus2.imem_addr, 32'd0);
        chk("wrap_req", 32'(bus2.imem_req), 32'd1);
        chk("wrap_fault", 32'(bus2.fault), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
